// File: rtl/stim_vector_player_if.sv
// Bus bundle for stim_vector_player: vector load port, run control, DUT drive/response
// and run status. The player uses the slave view; whoever loads and starts it (and
// closes the loop through the DUT) uses the master view.
interface stim_vector_player_if #(
  parameter int IN_W   = 2,
  parameter int EXP_W  = 1,
  parameter int ADDR_W = 4
);

  // Vector load port
  logic                    load_en;
  logic [ADDR_W-1:0]       load_addr;
  logic [IN_W+EXP_W-1:0]   load_data;

  // Run control
  logic [ADDR_W:0]         num_vec;
  logic                    start;

  // DUT loop
  logic [EXP_W-1:0]        dut_out;
  logic [IN_W-1:0]         dut_in;

  // Run status
  logic                    busy;
  logic                    done;
  logic [ADDR_W-1:0]       vec_idx;
  logic                    sample_valid;
  logic [ADDR_W:0]         mismatch_cnt;
  logic                    first_fail_valid;
  logic [ADDR_W-1:0]       first_fail_idx;

  modport master (
    output load_en,
    output load_addr,
    output load_data,
    output num_vec,
    output start,
    output dut_out,
    input  dut_in,
    input  busy,
    input  done,
    input  vec_idx,
    input  sample_valid,
    input  mismatch_cnt,
    input  first_fail_valid,
    input  first_fail_idx
  );

  modport slave (
    input  load_en,
    input  load_addr,
    input  load_data,
    input  num_vec,
    input  start,
    input  dut_out,
    output dut_in,
    output busy,
    output done,
    output vec_idx,
    output sample_valid,
    output mismatch_cnt,
    output first_fail_valid,
    output first_fail_idx
  );

endinterface

// File: rtl/stim_vector_player.sv
// Stimulus/response player: plays packed {inputs, expected} vectors from an internal
// RAM into a combinational DUT, holds each for HOLD cycles, samples the response at
// the end of the hold window and accumulates a mismatch count and first-fail index.
module stim_vector_player #(
  parameter int IN_W   = 2,
  parameter int EXP_W  = 1,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int HOLD   = 2
) (
  input logic                clk,
  input logic                rst,
  stim_vector_player_if.slave bus
);

  localparam int VEC_W = IN_W + EXP_W;
  localparam int HC_W  = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD - 1);
  localparam logic [ADDR_W:0] DEPTH_V   = (ADDR_W + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Vector storage; deliberately not reset so a run can be replayed after a reset
  logic [VEC_W-1:0]  r_mem [DEPTH];

  logic [1:0]        r_state;
  logic [ADDR_W:0]   r_n;
  logic [HC_W-1:0]   r_hold_cnt;
  logic [ADDR_W-1:0] r_vec_idx;
  logic [IN_W-1:0]   r_dut_in;
  logic              r_busy;
  logic              r_done;
  logic              r_sample_valid;
  logic [ADDR_W:0]   r_mismatch_cnt;
  logic              r_ff_valid;
  logic [ADDR_W-1:0] r_ff_idx;

  logic [1:0]        w_state_nxt;
  logic [ADDR_W:0]   w_n_nxt;
  logic [HC_W-1:0]   w_hold_nxt;
  logic [ADDR_W-1:0] w_idx_nxt;
  logic [IN_W-1:0]   w_dut_in_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic [ADDR_W:0]   w_mm_nxt;
  logic              w_ff_valid_nxt;
  logic [ADDR_W-1:0] w_ff_idx_nxt;

  logic              w_start_acc;
  logic              w_load_we;
  logic [ADDR_W:0]   w_n_start;
  logic [ADDR_W-1:0] w_idx_inc;
  logic [EXP_W-1:0]  w_cur_exp;
  logic [IN_W-1:0]   w_next_in;
  logic [IN_W-1:0]   w_first_in;
  logic              w_sample;
  logic              w_mismatch;
  logic              w_more;

  // Start is a level, honoured only outside RUN; it takes priority over a load
  assign w_start_acc = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_load_we   = bus.load_en && (r_state != ST_RUN) && !w_start_acc;
  assign w_n_start   = (bus.num_vec > DEPTH_V) ? DEPTH_V : bus.num_vec;

  assign w_idx_inc  = r_vec_idx + ADDR_W'(1);
  assign w_cur_exp  = r_mem[r_vec_idx][EXP_W-1:0];
  assign w_next_in  = r_mem[w_idx_inc][VEC_W-1:EXP_W];
  assign w_first_in = r_mem[0][VEC_W-1:EXP_W];

  // Sample at the last cycle of the hold window, when the DUT inputs have settled
  assign w_sample   = (r_state == ST_RUN) && (r_hold_cnt == HOLD_LAST);
  assign w_mismatch = w_sample && (bus.dut_out != w_cur_exp);
  assign w_more     = ({1'b0, r_vec_idx} + (ADDR_W + 1)'(1)) < r_n;

  // Vector RAM write port
  always_ff @(posedge clk) begin
    if (w_load_we) begin
      r_mem[bus.load_addr] <= bus.load_data;
    end
  end

  // Next-state logic for the run sequencer and its result registers
  always_comb begin
    w_state_nxt    = r_state;
    w_n_nxt        = r_n;
    w_hold_nxt     = r_hold_cnt;
    w_idx_nxt      = r_vec_idx;
    w_dut_in_nxt   = r_dut_in;
    w_busy_nxt     = r_busy;
    w_done_nxt     = r_done;
    w_mm_nxt       = r_mismatch_cnt;
    w_ff_valid_nxt = r_ff_valid;
    w_ff_idx_nxt   = r_ff_idx;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start_acc) begin
          w_n_nxt        = w_n_start;
          w_mm_nxt       = '0;
          w_ff_valid_nxt = 1'b0;
          w_ff_idx_nxt   = '0;
          w_done_nxt     = 1'b0;
          if (w_n_start == '0) begin
            // Empty run: finish immediately, leave the DUT drive untouched
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt  = ST_RUN;
            w_busy_nxt   = 1'b1;
            w_idx_nxt    = '0;
            w_dut_in_nxt = w_first_in;
            w_hold_nxt   = '0;
          end
        end
      end

      ST_RUN: begin
        w_hold_nxt = r_hold_cnt + HC_W'(1);
        if (w_sample) begin
          if (w_mismatch) begin
            w_mm_nxt = r_mismatch_cnt + (ADDR_W + 1)'(1);
            if (!r_ff_valid) begin
              w_ff_valid_nxt = 1'b1;
              w_ff_idx_nxt   = r_vec_idx;
            end
          end
          w_hold_nxt = '0;
          if (w_more) begin
            w_idx_nxt    = w_idx_inc;
            w_dut_in_nxt = w_next_in;
          end else begin
            // Last vector stays on the DUT inputs after the run
            w_state_nxt = ST_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any run in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_n            <= '0;
      r_hold_cnt     <= '0;
      r_vec_idx      <= '0;
      r_dut_in       <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_sample_valid <= 1'b0;
      r_mismatch_cnt <= '0;
      r_ff_valid     <= 1'b0;
      r_ff_idx       <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_n            <= w_n_nxt;
      r_hold_cnt     <= w_hold_nxt;
      r_vec_idx      <= w_idx_nxt;
      r_dut_in       <= w_dut_in_nxt;
      r_busy         <= w_busy_nxt;
      r_done         <= w_done_nxt;
      r_sample_valid <= w_sample;
      r_mismatch_cnt <= w_mm_nxt;
      r_ff_valid     <= w_ff_valid_nxt;
      r_ff_idx       <= w_ff_idx_nxt;
    end
  end

  assign bus.dut_in           = r_dut_in;
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.vec_idx          = r_vec_idx;
  assign bus.sample_valid     = r_sample_valid;
  assign bus.mismatch_cnt     = r_mismatch_cnt;
  assign bus.first_fail_valid = r_ff_valid;
  assign bus.first_fail_idx   = r_ff_idx;

endmodule

// File: tb/tb_stim_vector_player.sv
// Bench for stim_vector_player driving a one-bit AND DUT. A vector-level reference
// model predicts, for every cycle of a run, the DUT drive, status flags and the
// running mismatch statistics from the loaded vector table.
module tb_stim_vector_player;

  localparam int IN_W   = 2;
  localparam int EXP_W  = 1;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int HOLD   = 2;

  logic clk;
  logic rst;

  stim_vector_player_if #(.IN_W(IN_W), .EXP_W(EXP_W), .ADDR_W(ADDR_W)) bus ();

  stim_vector_player #(
    .IN_W  (IN_W),
    .EXP_W (EXP_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .HOLD  (HOLD)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Device under stimulus: a plain AND gate
  assign bus.dut_out = bus.dut_in[1] & bus.dut_in[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] m_mem [DEPTH];
  logic [1:0] m_dut_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_bad(input int j);
    return m_mem[j][0] != (m_mem[j][2] & m_mem[j][1]);
  endfunction

  task automatic load_vec(input int addr, input logic [2:0] data);
    @(negedge clk);
    bus.load_en   = 1'b1;
    bus.load_addr = addr[3:0];
    bus.load_data = data;
    @(negedge clk);
    bus.load_en   = 1'b0;
    m_mem[addr]   = data;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".dut_in"}, 32'(bus.dut_in), 0);
    check({tag, ".busy"}, 32'(bus.busy), 0);
    check({tag, ".done"}, 32'(bus.done), 0);
    check({tag, ".vec_idx"}, 32'(bus.vec_idx), 0);
    check({tag, ".sv"}, 32'(bus.sample_valid), 0);
    check({tag, ".mm"}, 32'(bus.mismatch_cnt), 0);
    check({tag, ".ffv"}, 32'(bus.first_fail_valid), 0);
    check({tag, ".ffi"}, 32'(bus.first_fail_idx), 0);
  endtask

  // One run from IDLE/DONE. coload: load slot 0 on the start edge (must be dropped).
  // poke: start+load mid-run (ignored). abort_at: reset after that cycle of the run.
  task automatic play(input int num, input bit coload, input bit poke, input int abort_at);
    int n, idx, mm, ffi, pulses;
    bit ffv;
    n = (num > DEPTH) ? DEPTH : num;
    pulses = 0;
    @(negedge clk);
    bus.num_vec = num[4:0];
    bus.start   = 1'b1;
    if (coload) begin
      bus.load_en   = 1'b1;
      bus.load_addr = 4'd0;
      bus.load_data = ~m_mem[0];
    end
    for (int t = 0; t <= n * HOLD; t++) begin
      @(posedge clk);
      #1;
      if (t == 0) begin
        bus.start   = 1'b0;
        bus.load_en = 1'b0;
      end
      mm = 0; ffv = 0; ffi = 0;
      for (int j = 0; j < n; j++) begin
        if ((j + 1) * HOLD <= t && is_bad(j)) begin
          if (!ffv) begin
            ffv = 1;
            ffi = j;
          end
          mm++;
        end
      end
      if (n == 0) begin
        check("empty.dut_in", 32'(bus.dut_in), 32'(m_dut_in));
        check("empty.busy", 32'(bus.busy), 0);
        check("empty.done", 32'(bus.done), 1);
        check("empty.sv", 32'(bus.sample_valid), 0);
      end else begin
        idx = t / HOLD;
        if (idx > n - 1) idx = n - 1;
        check("run.dut_in", 32'(bus.dut_in), 32'(m_mem[idx][2:1]));
        check("run.vec_idx", 32'(bus.vec_idx), 32'(idx));
        check("run.busy", 32'(bus.busy), 32'(t < n * HOLD));
        check("run.done", 32'(bus.done), 32'(t == n * HOLD));
        check("run.sv", 32'(bus.sample_valid), 32'(t > 0 && (t % HOLD) == 0));
      end
      check("run.mm", 32'(bus.mismatch_cnt), 32'(mm));
      check("run.ffv", 32'(bus.first_fail_valid), 32'(ffv));
      check("run.ffi", 32'(bus.first_fail_idx), 32'(ffi));
      if (bus.sample_valid === 1'b1) pulses++;
      if (poke && t == 2) begin
        bus.start     = 1'b1;
        bus.load_en   = 1'b1;
        bus.load_addr = 4'd0;
        bus.load_data = ~m_mem[0];
      end
      if (poke && t == 3) begin
        bus.start   = 1'b0;
        bus.load_en = 1'b0;
      end
      if (t == abort_at) begin
        #2 rst = 1'b1;
        #1 check_all_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        m_dut_in = '0;
        return;
      end
    end
    check("pulses", 32'(pulses), 32'(n));
    if (n > 0) m_dut_in = m_mem[n-1][2:1];
  endtask

  initial begin
    rst           = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.num_vec   = '0;
    bus.start     = 1'b0;
    m_dut_in      = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;
    #2 rst = 1'b1;
    #3 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // AND truth table, all passing
    load_vec(0, 3'b000);
    load_vec(1, 3'b010);
    load_vec(2, 3'b100);
    load_vec(3, 3'b111);
    play(4, 0, 0, -1);

    // Single failing vector in slot 2; slot 3 still played
    load_vec(2, 3'b101);
    play(4, 0, 0, -1);

    // Empty run
    play(0, 0, 0, -1);

    // Fill the whole RAM and over-request
    for (int i = 0; i < DEPTH; i++) load_vec(i, 3'($urandom));
    play(20, 0, 0, -1);

    // Abort mid-run, then replay from the preserved RAM
    play(16, 0, 0, 3);
    play(16, 0, 0, -1);

    // start/load during RUN ignored, then restart from DONE
    play(4, 0, 1, -1);
    play(4, 0, 0, -1);

    // start beats a simultaneous load
    play(5, 1, 0, -1);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 4; k++) load_vec($urandom_range(0, DEPTH - 1), 3'($urandom));
      play($urandom_range(0, 20), 1'($urandom), 0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stim_vector_player.md
Name: stim_vector_player

Overview:
- Synthesizable stimulus/response stage that sits directly upstream of a small combinational DUT such as a one-bit AND.
- Holds a RAM of packed test vectors in {inputs, expected} format, loaded through a write port.
- On start, drives each vector's inputs to the DUT for HOLD cycles, then samples the DUT output and compares it against the expected field.
- Reports a mismatch count and the index of the first failing vector, so regression runs no longer depend on file-driven benches.

Parameters:
- IN_W, 2, width of DUT input field (MSBs of each vector).
- EXP_W, 1, width of expected-output field (LSBs of each vector).
- DEPTH, 16, number of vector slots; must be a power of two.
- ADDR_W, 4, log2(DEPTH).
- HOLD, 2, cycles each vector is applied before sampling; must be >= 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_en  in  1  write load_data into slot load_addr.
- load_addr  in  ADDR_W  vector slot index.
- load_data  in  IN_W+EXP_W  packed vector {inputs, expected}.
- num_vec  in  ADDR_W+1  number of vectors to play; sampled on accepted start.
- start  in  1  begin a run (level, accepted only in IDLE or DONE).
- dut_out  in  EXP_W  DUT response.
- dut_in  out  IN_W  registered drive to DUT inputs.
- busy  out  1  high while playing vectors.
- done  out  1  high from run completion until next accepted start.
- vec_idx  out  ADDR_W  index of vector currently driven.
- sample_valid  out  1  one-cycle pulse when a comparison is made.
- mismatch_cnt  out  ADDR_W+1  failing vectors in the current or last run.
- first_fail_valid  out  1  at least one mismatch seen this run.
- first_fail_idx  out  ADDR_W  index of the first mismatch.

Behaviour:
- Reset (async): state=IDLE. All outputs are 0: dut_in, busy, done, vec_idx, sample_valid, mismatch_cnt, first_fail_valid, first_fail_idx. Vector RAM is not cleared.
- Reset mid-run aborts the run immediately. RAM contents are preserved, so a subsequent start replays the same vectors.
- States: IDLE, RUN, DONE.
- Load: written at the clock edge when load_en=1, state is not RUN, and start is not accepted that cycle.
  - Loads during RUN are ignored.
  - Start wins over a simultaneous load.
- Start accepted in IDLE or DONE. At edge k:
  - latch n = min(num_vec, DEPTH);
  - clear mismatch_cnt, first_fail_valid, first_fail_idx, done.
  - If n=0: go to DONE with done=1 after edge k; dut_in is unchanged and no samples are taken.
  - Else: go to RUN with busy=1, vec_idx=0, dut_in=mem[0] input field, hold_cnt=0, all after edge k.
- RUN:
  - hold_cnt increments each cycle.
  - At the edge where hold_cnt==HOLD-1, compare dut_out against mem[vec_idx] expected field and assert sample_valid for the following cycle.
  - On mismatch: mismatch_cnt+1. If first_fail_valid=0, set it and load first_fail_idx=vec_idx.
  - On the same edge, if vec_idx<n-1: vec_idx+1, dut_in=next vector inputs, hold_cnt=0.
  - Otherwise go to DONE: busy=0, done=1. dut_in holds the last vector.
- Timing: vector i is driven after edge k+i*HOLD and sampled at edge k+(i+1)*HOLD. The final sample and done are at edge k+n*HOLD.
- start while in RUN is ignored. start held high in DONE restarts on the next edge.
- mismatch_cnt cannot exceed DEPTH, so its width is sufficient and no saturation logic is needed.
- The DUT is purely combinational; the sample point at the end of the hold window guarantees settled inputs for HOLD >= 1.

Test Plan:
- Load slots 0-3 with 000,010,100,111 (AND truth table); DUT=AND; num_vec=4, HOLD=2; start at edge k -> dut_in sequence 00,01,10,11 changing every 2 cycles; four sample_valid pulses; done=1 after edge k+8; mismatch_cnt=0; first_fail_valid=0.
- Same setup with slot 2 loaded as 101 -> mismatch_cnt=1, first_fail_valid=1, first_fail_idx=2; slot 3 is still played.
- num_vec=0, start -> done=1 one edge later; busy never asserts; mismatch_cnt=0; dut_in unchanged.
- num_vec=20, all 16 slots loaded -> exactly 16 sample_valid pulses; done after 32 cycles.
- Assert rst at cycle 3 of a run -> all outputs 0 immediately; re-start -> full run is reproduced from the unchanged RAM.
- Pulse start and load_en (slot 0, new data) during RUN -> both ignored; run completes normally. Then start from DONE -> counters clear and the run repeats.
